// File: rtl/mem_read_arbiter_pkg.sv
// Shared defaults and state encoding for the graph-memory read arbiter.
package mem_read_arbiter_pkg;

    localparam int DEFAULT_ARB_PORTS   = 2;
    localparam int DEFAULT_MEM_TIMEOUT = 256;
    localparam int DEFAULT_MADDR_WIDTH = 16;
    localparam int DEFAULT_MDATA_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_read_arbiter_picker.sv
// Round-robin picker: first requesting port after last_grant, wrapping modulo NUM_PORTS.
module rr_priority_picker #(
    parameter int NUM_PORTS     = 2,
    parameter int PORT_ID_WIDTH = 1
) (
    input  logic [NUM_PORTS-1:0]     req_i,
    input  logic [PORT_ID_WIDTH-1:0] last_grant_i,
    output logic [PORT_ID_WIDTH-1:0] grant_o,
    output logic                     any_req_o
);

    int                       idx;
    logic                     found;
    logic [PORT_ID_WIDTH-1:0] sel;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_PORTS;
            sel = PORT_ID_WIDTH'(idx);
            if (!found && req_i[sel]) begin
                found   = 1'b1;
                grant_o = sel;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one graph-memory read port among NUM_PORTS requesters, one outstanding read at a time.
//
// state   | meaning
// IDLE    | no transaction; arbitrate among req_valid
// WAIT    | read issued to memory, waiting for mem_read_ready or timeout
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = DEFAULT_ARB_PORTS,
    parameter int PORT_ID_WIDTH  = 1,
    parameter int MADDR_WIDTH    = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_MEM_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*MADDR_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [MDATA_WIDTH-1:0]         rsp_data,
    output logic                           rsp_error,
    output logic [MADDR_WIDTH-1:0]         mem_addr,
    output logic                           mem_read_enable,
    input  logic                           mem_read_ready,
    input  logic [MDATA_WIDTH-1:0]         mem_data,
    output logic                           busy,
    output logic [PORT_ID_WIDTH-1:0]       grant_id
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e               state_q, state_d;
    logic [PORT_ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [PORT_ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [MADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                     mem_en_q, mem_en_d;
    logic [NUM_PORTS-1:0]     req_ready_q, req_ready_d;
    logic [NUM_PORTS-1:0]     rsp_valid_q, rsp_valid_d;
    logic                     rsp_error_q, rsp_error_d;
    logic [MDATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [PORT_ID_WIDTH-1:0] pick;
    logic                     any_req;

    rr_priority_picker #(
        .NUM_PORTS     (NUM_PORTS),
        .PORT_ID_WIDTH (PORT_ID_WIDTH)
    ) u_picker (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_req_o    (any_req)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        mem_addr_d   = mem_addr_q;
        mem_en_d     = mem_en_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_error_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_id_d        = pick;
                    last_grant_d      = pick;
                    mem_addr_d        = req_addr[pick*MADDR_WIDTH +: MADDR_WIDTH];
                    mem_en_d          = 1'b1;
                    req_ready_d[pick] = 1'b1;
                    cnt_d             = '0;
                    state_d           = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_read_ready) begin
                    rsp_data_d              = mem_data;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    mem_en_d                = 1'b0;
                    state_d                 = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Forced error response so a stuck memory cannot hang the requester.
                    rsp_data_d              = '0;
                    rsp_error_d             = 1'b1;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    mem_en_d                = 1'b0;
                    state_d                 = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_ID_WIDTH'(NUM_PORTS - 1);
            grant_id_q   <= '0;
            mem_addr_q   <= '0;
            mem_en_q     <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_error_q  <= 1'b0;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mem_addr_q   <= mem_addr_d;
            mem_en_q     <= mem_en_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_data_q   <= rsp_data_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_error       = rsp_error_q;
    assign rsp_data        = rsp_data_q;
    assign mem_addr        = mem_addr_q;
    assign mem_read_enable = mem_en_q;
    assign grant_id        = grant_id_q;
    assign busy            = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: 3 ports, timeout of 8 cycles.
module tb_mem_read_arbiter;

    localparam int NP  = 3;
    localparam int IDW = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TO  = 8;

    logic              clock;
    logic              reset;
    logic [NP-1:0]     req_valid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_error;
    logic [AW-1:0]     mem_addr;
    logic              mem_read_enable;
    logic              mem_read_ready;
    logic [DW-1:0]     mem_data;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    mem_read_arbiter #(
        .NUM_PORTS      (NP),
        .PORT_ID_WIDTH  (IDW),
        .MADDR_WIDTH    (AW),
        .MDATA_WIDTH    (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .mem_addr        (mem_addr),
        .mem_read_enable (mem_read_enable),
        .mem_read_ready  (mem_read_ready),
        .mem_data        (mem_data),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0]  g;
        logic [15:0] a0, a1;
        reset          = 1'b1;
        req_valid      = '0;
        req_addr       = '0;
        mem_read_ready = 1'b0;
        mem_data       = '0;
        tick();
        tick();

        // reset state
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_en",    32'(mem_read_enable), 32'h0);
        chk("rst_rdy",   32'(req_ready), 32'h0);
        chk("rst_rsp",   32'(rsp_valid), 32'h0);
        chk("rst_data",  32'(rsp_data), 32'h0);
        chk("rst_gid",   32'(grant_id), 32'h0);
        chk("rst_addr",  32'(mem_addr), 32'h0);
        reset = 1'b0;

        // 1: single read from port 0, memory answers 3 cycles after grant
        req_valid          = 3'b001;
        req_addr[0*AW +: AW] = 16'h0040;
        tick();
        chk("t1_ready",  32'(req_ready), 32'h1);
        chk("t1_addr",   32'(mem_addr), 32'h40);
        chk("t1_en",     32'(mem_read_enable), 32'h1);
        chk("t1_busy",   32'(busy), 32'h1);
        req_valid = '0;
        tick();
        chk("t1_ready_pulse", 32'(req_ready), 32'h0);
        tick();
        chk("t1_en_held", 32'(mem_read_enable), 32'h1);
        chk("t1_no_rsp",  32'(rsp_valid), 32'h0);
        mem_read_ready = 1'b1;
        mem_data       = 32'h1234;
        tick();
        chk("t1_rsp",     32'(rsp_valid), 32'h1);
        chk("t1_data",    rsp_data, 32'h1234);
        chk("t1_err",     32'(rsp_error), 32'h0);
        chk("t1_en_off",  32'(mem_read_enable), 32'h0);
        chk("t1_busy_off", 32'(busy), 32'h0);
        mem_read_ready = 1'b0;
        tick();
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);
        chk("t1_data_hold", rsp_data, 32'h1234);

        // 2: ports 0 and 1 request continuously; last grant was 0 so port 1 goes first
        a0 = 16'h0100;
        a1 = 16'h0200;
        req_addr[0*AW +: AW] = a0;
        req_addr[1*AW +: AW] = a1;
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 0) ? 3'd1 : 3'd0;
            tick();
            chk("t2_ready", 32'(req_ready), 32'(3'b001 << g));
            chk("t2_gid",   32'(grant_id), 32'(g));
            chk("t2_addr",  32'(mem_addr), (g == 3'd1) ? 32'h200 : 32'h100);
            mem_read_ready = 1'b1;
            mem_data       = 32'hA000 + 32'(i);
            tick();
            chk("t2_rsp",   32'(rsp_valid), 32'(3'b001 << g));
            chk("t2_data",  rsp_data, 32'hA000 + 32'(i));
            mem_read_ready = 1'b0;
        end
        req_valid = '0;
        tick();

        // 3: port 2 granted, then ports 1 and 2 request together
        req_addr[2*AW +: AW] = 16'h0300;
        req_valid = 3'b100;
        tick();
        chk("t3_g2_ready", 32'(req_ready), 32'h4);
        chk("t3_g2_addr",  32'(mem_addr), 32'h300);
        req_valid      = '0;
        mem_read_ready = 1'b1;
        mem_data       = 32'h3333;
        tick();
        chk("t3_g2_rsp", 32'(rsp_valid), 32'h4);
        mem_read_ready = 1'b0;
        req_valid      = 3'b110;
        tick();
        chk("t3_g1_ready", 32'(req_ready), 32'h2);
        chk("t3_g1_gid",   32'(grant_id), 32'h1);
        req_valid      = 3'b100;
        mem_read_ready = 1'b1;
        mem_data       = 32'h1111;
        tick();
        chk("t3_g1_rsp", 32'(rsp_valid), 32'h2);
        mem_read_ready = 1'b0;
        tick();
        chk("t3_g2b_ready", 32'(req_ready), 32'h4);
        chk("t3_g2b_gid",   32'(grant_id), 32'h2);
        req_valid      = '0;
        mem_read_ready = 1'b1;
        mem_data       = 32'h2222;
        tick();
        chk("t3_g2b_rsp",  32'(rsp_valid), 32'h4);
        chk("t3_g2b_data", rsp_data, 32'h2222);
        mem_read_ready = 1'b0;

        // 4: memory never answers; error response 8 cycles after grant
        req_addr[0*AW +: AW] = 16'h0055;
        req_valid = 3'b001;
        tick();
        chk("t4_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("t4_wait_rsp", 32'(rsp_valid), 32'h0);
            chk("t4_wait_en",  32'(mem_read_enable), 32'h1);
        end
        tick();
        chk("t4_rsp",    32'(rsp_valid), 32'h1);
        chk("t4_err",    32'(rsp_error), 32'h1);
        chk("t4_data",   rsp_data, 32'h0);
        chk("t4_en_off", 32'(mem_read_enable), 32'h0);
        chk("t4_busy",   32'(busy), 32'h0);
        req_addr[1*AW +: AW] = 16'h0066;
        req_valid = 3'b010;
        tick();
        chk("t4_next_ready", 32'(req_ready), 32'h2);
        chk("t4_next_addr",  32'(mem_addr), 32'h66);
        chk("t4_err_pulse",  32'(rsp_error), 32'h0);
        req_valid      = '0;
        mem_read_ready = 1'b1;
        mem_data       = 32'h77;
        tick();
        chk("t4_next_rsp",  32'(rsp_valid), 32'h2);
        chk("t4_next_err",  32'(rsp_error), 32'h0);
        chk("t4_next_data", rsp_data, 32'h77);
        mem_read_ready = 1'b0;

        // 5: reset during WAIT, then a late ready
        req_addr[1*AW +: AW] = 16'h0088;
        req_valid = 3'b010;
        tick();
        chk("t5_ready", 32'(req_ready), 32'h2);
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("t5_en",   32'(mem_read_enable), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_addr", 32'(mem_addr), 32'h0);
        chk("t5_gid",  32'(grant_id), 32'h0);
        chk("t5_data", rsp_data, 32'h0);
        reset          = 1'b0;
        mem_read_ready = 1'b1;
        mem_data       = 32'hDEAD;
        tick();
        chk("t5_late_rsp",  32'(rsp_valid), 32'h0);
        chk("t5_late_data", rsp_data, 32'h0);
        mem_read_ready = 1'b0;
        req_addr[0*AW +: AW] = 16'h0099;
        req_valid = 3'b011;
        tick();
        chk("t5_first_ready", 32'(req_ready), 32'h1);
        chk("t5_first_addr",  32'(mem_addr), 32'h99);
        req_valid      = '0;
        mem_read_ready = 1'b1;
        mem_data       = 32'h99;
        tick();
        chk("t5_first_rsp", 32'(rsp_valid), 32'h1);
        mem_read_ready = 1'b0;

        // 6: ready pulse while idle is ignored
        tick();
        mem_read_ready = 1'b1;
        mem_data       = 32'hBEEF;
        tick();
        chk("t6_rsp",  32'(rsp_valid), 32'h0);
        chk("t6_data", rsp_data, 32'h99);
        chk("t6_busy", 32'(busy), 32'h0);
        mem_read_ready = 1'b0;
        tick();
        chk("t6_busy2", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
